// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and bit-period derivation
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  localparam int CNT_W = 16;

  // Rounded so uart_tx and uart_rx derive the identical bit period.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte holding register handshake and status pulses
interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;

  modport master (output data_out, data_valid, frame_err, overrun, input data_ready);
  modport slave  (input data_out, data_valid, frame_err, overrun, output data_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchronizer with falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic [1:0] armed;

  // The edge register is only armed once the synchronizer holds real pin
  // samples, so a line held low through reset never looks like a 1->0 edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      prev  <= 1'b0;
      armed <= 2'b00;
    end else begin
      meta  <= din;
      sync  <= meta;
      armed <= {armed[0], 1'b1};
      prev  <= sync & armed[1];
    end
  end

  assign dout = sync;
  assign fall = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit majority vote and holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  uart_rx_if.master   bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] VOTE_AT  = CNT_W'(HALF + 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             smp_a, smp_b;
  logic             line, fall, vote, at_vote, wrap, good, bad;

  uart_rx_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (rx_in),
    .dout (line),
    .fall (fall)
  );

  assign at_vote = (cnt_q == VOTE_AT);
  assign wrap    = (cnt_q == CNT_LAST);
  // Third sample is the live synchronized line at the vote cycle.
  assign vote    = (smp_a & smp_b) | (smp_a & line) | (smp_b & line);

  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    good    = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (at_vote) shift_d[idx_q] = vote;
        if (wrap) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (at_vote) begin
          if (vote) begin
            good    = 1'b1;
            state_d = IDLE;
          end else begin
            bad     = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      smp_a          <= 1'b0;
      smp_b          <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      if (cnt_q == SAMPLE_A) smp_a <= line;
      if (cnt_q == SAMPLE_B) smp_b <= line;
      bus.frame_err <= bad;
      bus.overrun   <= good && bus.data_valid && !bus.data_ready;
      if (good && (!bus.data_valid || bus.data_ready)) begin
        bus.data_out   <= shift_q;
        bus.data_valid <= 1'b1;
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first. It is the receive-side counterpart of `uart_tx` on the board's 12 MHz `hw_clk` domain. The block synchronizes the RX pin, detects and validates the start bit, and takes a 3-sample majority vote at mid-bit. It delivers each byte through a valid/ready holding register and reports framing errors and overruns as single-cycle pulses.

## Interface
- `CLK_HZ`, 12000000, system clock frequency.
- `BAUD`, 115200, line rate.
- `CLKS_PER_BIT`, round(CLK_HZ/BAUD) = 104, bit period in clocks; must be ≥ 8.
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-low (0 = reset).
- `rx_in` in 1: asynchronous serial input, idle high.
- `data_out` out 8: received byte, stable while `data_valid` = 1.
- `data_valid` out 1: byte available in the holding register.
- `data_ready` in 1: consumer accepts the byte when `data_valid & data_ready`.
- `frame_err` out 1: 1-cycle pulse, stop bit sampled low.
- `overrun` out 1: 1-cycle pulse, a byte was dropped because the holding register was full.

## Operation
- **Synchronizer and edge detect:** 2-FF synchronizer on `rx_in` (reset value 1), then an edge-detect register (reset value 0). A start candidate is a synchronized 1→0 transition only. A line held low through reset does not start a frame.
- **Bit timing:** `HALF` = CLKS_PER_BIT/2 (52).
  - The bit counter runs 0..CLKS_PER_BIT-1 and wraps, advancing the bit index on each wrap.
  - Samples are taken at cnt = HALF-1, HALF and HALF+1.
  - The majority vote is evaluated at cnt = HALF+1.
- **States:**
  - **IDLE:** on a start candidate go to START; cnt←0.
  - **START:** if the vote = 1 (glitch), return to IDLE with no output. Otherwise continue counting; at the wrap go to DATA with bit index 0.
  - **DATA:** the vote is shifted into bit [index], LSB first. After index 7 wraps, go to STOP.
  - **STOP, vote = 1:** frame good. Go straight to IDLE at mid-stop so a following start edge is caught.
  - **STOP, vote = 0:** pulse `frame_err` and discard the byte. Go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until the synchronized line = 1, then go to IDLE. This absorbs break conditions.
- **Holding register**, on a good frame:
  - If `data_valid` = 0, or `data_ready` = 1 in the same cycle: load `data_out` and set `data_valid`.
  - Else: keep the old byte and pulse `overrun`.
  - `data_valid` clears on `data_valid & data_ready` when no new load happens that cycle.
- **Reset values:** `data_out` = 0x00, `data_valid` = 0, `frame_err` = 0, `overrun` = 0, state = IDLE, counters = 0.
- **Reset mid-frame:** the partial byte is lost and no pulse is generated. A byte already in the holding register is cleared.

## Timing
- Synchronizer latency: 2 cycles from the `rx_in` pin to the synchronized signal.
- Let t0 be the cycle in which the synchronized falling edge is seen:
  - START vote at t0+HALF+2.
  - Data bit n vote at t0+(n+1)·CLKS_PER_BIT+HALF+2.
  - Stop vote at t0+9·CLKS_PER_BIT+HALF+2 = t0+990.
- `data_valid`, `data_out`, `frame_err` and `overrun` are registered and change at the stop vote cycle +1 (t0+991 with defaults).
- Back-to-back frames are supported with zero idle bits. The receiver is back in IDLE about 0.5 bit before the stop bit ends.
- Tolerated baud mismatch: ±3 % at defaults.

## Structure
- Shared package `uart_pkg` holds:
  - state encodings (IDLE, START, DATA, STOP, WAIT_HIGH);
  - the `CLKS_PER_BIT` derivation from CLK_HZ/BAUD, shared with `uart_tx` so both ends match.
- Sub-module `uart_rx_sync`: 2-FF synchronizer plus falling-edge detect. It is reusable for the I2C SDA/SCL inputs.
- Main FSM, counters, shift register and holding register stay in `uart_rx`.

## Test plan
- **Single byte:** send 0xA5 at 115200 with `data_ready` = 1 → `data_out` = 0xA5, `data_valid` high for 1 cycle at t0+991, no error pulses.
- **Back-to-back:** 0x00 then 0xFF with zero idle gap, `data_ready` held 1 → two valid bytes 0x00, 0xFF exactly 1040 cycles apart.
- **Glitch:** `rx_in` low for 30 cycles, then high → no `data_valid`, no `frame_err`, FSM back in IDLE by t0+55.
- **Framing error:** send 0x55 with stop bit = 0, line low for 2 bit times, then 0x3C → one `frame_err` pulse and no valid for 0x55; 0x3C then received correctly.
- **Overrun:** send 0x11 then 0x22 with `data_ready` = 0 → `data_out` stays 0x11 and one `overrun` pulse. Separately, asserting `data_ready` on the exact load cycle of 0x22 → `data_out` = 0x22 with no overrun.
- **Reset:** assert `reset` = 0 mid-byte with the line held low, then release → all outputs 0, no false start until a new 1→0 edge; the next 0x96 is received correctly.
